// File: rtl/bcd_msg_serializer_if.sv
// Byte stream from the message serializer to the UART transmitter.
`timescale 1ns/1ps
interface bcd_msg_serializer_if;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_ready;

    modport master (output out_byte, output out_valid, input out_ready);
    modport slave  (input out_byte, input out_valid, output out_ready);
endinterface

// File: rtl/bcd_msg_serializer.sv
// Formats NUM_CH signed fixed-point BCD readings as one ASCII line and streams
// it byte by byte over a valid/ready handshake.
`timescale 1ns/1ps
module bcd_msg_serializer #(
    parameter int INT_DIGITS    = 2,
    parameter int FRAC_DIGITS   = 1,
    parameter int NUM_CH        = 2,
    parameter int PERIOD_CYCLES = 100000000
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic [NUM_CH*4*(INT_DIGITS+FRAC_DIGITS)-1:0]   bcd_in,
    input  logic [NUM_CH-1:0]                              neg_in,
    input  logic                                           unit_f,
    input  logic                                           force_send,
    bcd_msg_serializer_if.master                           tx,
    output logic                                           busy,
    output logic                                           msg_done
);
    localparam int NDIG    = INT_DIGITS + FRAC_DIGITS;
    localparam int CH_W    = 4 * NDIG;
    localparam int BCD_W   = NUM_CH * CH_W;
    localparam int DOT_N   = (FRAC_DIGITS > 0) ? 1 : 0;
    localparam int UNIT_SP = 5 + NDIG + DOT_N;
    // Each channel also owns its two trailing bytes: ", " or CR LF.
    localparam int FLD_N   = UNIT_SP + 4;
    localparam int FLD_W   = $clog2(FLD_N);
    localparam int CH_IW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TMR_W   = (PERIOD_CYCLES > 0) ? $clog2(PERIOD_CYCLES + 1) : 1;

    localparam logic [FLD_W-1:0] FLD_LAST = FLD_W'(FLD_N - 1);
    localparam logic [CH_IW-1:0] CH_LAST  = CH_IW'(NUM_CH - 1);
    localparam logic [TMR_W-1:0] PER_LAST = (PERIOD_CYCLES > 0) ? TMR_W'(PERIOD_CYCLES - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CH_IW-1:0]   ch_q, ch_d;
    logic [FLD_W-1:0]   fld_q, fld_d;
    logic [BCD_W-1:0]   snap_bcd_q;
    logic [NUM_CH-1:0]  snap_neg_q;
    logic               snap_unit_q;
    logic               start_pend_q, start_pend_d;
    logic               force_pend_q, force_pend_d;
    logic               per_pend_q, per_pend_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               per_hit;
    logic               trigger;
    logic [7:0]         byte_c;

    function automatic logic [7:0] digit_char(input logic [CH_W-1:0] v, input int d);
        logic [3:0] nib;
        nib = 4'(v >> (4 * (NDIG - 1 - d)));
        return (nib > 4'd9) ? 8'h3F : {4'h3, nib};
    endfunction

    assign per_hit = (PERIOD_CYCLES > 0) && (timer_q == PER_LAST);

    // The snapshot doubles as the last-sent copy used for on-change detection.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d  = state_q;
        ch_d     = ch_q;
        fld_d    = fld_q;
        msg_done = 1'b0;
        trigger  = start_pend_q | force_pend_q | per_pend_q | per_hit
                 | ({bcd_in, neg_in, unit_f} != {snap_bcd_q, snap_neg_q, snap_unit_q});
        case (state_q)
            S_IDLE: if (trigger) state_d = S_LOAD;
            S_LOAD: begin
                state_d = S_SEND;
                ch_d    = '0;
                fld_d   = '0;
            end
            S_SEND: if (tx.out_ready) begin
                if (fld_q == FLD_LAST) begin
                    fld_d = '0;
                    if (ch_q == CH_LAST) state_d = S_DONE;
                    else                 ch_d    = ch_q + 1'b1;
                end else begin
                    fld_d = fld_q + 1'b1;
                end
            end
            S_DONE: begin
                msg_done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A force pulse coinciding with LOAD survives to request the following message.
    always_comb begin
        start_pend_d = start_pend_q & (state_q != S_LOAD);
        force_pend_d = force_send | (force_pend_q & (state_q != S_LOAD));
        per_pend_d   = (per_pend_q | per_hit) & (state_q != S_LOAD);
        if (state_d == S_LOAD)   timer_d = '0;
        else if (timer_q == '1)  timer_d = timer_q;
        else                     timer_d = timer_q + 1'b1;
    end

    always_comb begin
        logic [CH_W-1:0] ch_bcd;
        int              fld;
        ch_bcd = snap_bcd_q[int'(ch_q)*CH_W +: CH_W];
        fld    = int'(fld_q);
        byte_c = 8'h20;
        if      (fld == 0)                        byte_c = 8'h54;
        else if (fld == 1)                        byte_c = {4'h3, 4'(ch_q)};
        else if (fld == 2)                        byte_c = 8'h3A;
        else if (fld == 3)                        byte_c = 8'h20;
        else if (fld == 4)                        byte_c = snap_neg_q[ch_q] ? 8'h2D : 8'h2B;
        else if (fld < 5 + INT_DIGITS)            byte_c = digit_char(ch_bcd, fld - 5);
        else if (DOT_N == 1 && fld == 5 + INT_DIGITS) byte_c = 8'h2E;
        else if (fld < UNIT_SP)                   byte_c = digit_char(ch_bcd, fld - 5 - DOT_N);
        else if (fld == UNIT_SP)                  byte_c = 8'h20;
        else if (fld == UNIT_SP + 1)              byte_c = snap_unit_q ? 8'h46 : 8'h43;
        else if (fld == UNIT_SP + 2)              byte_c = (ch_q == CH_LAST) ? 8'h0D : 8'h2C;
        else                                      byte_c = (ch_q == CH_LAST) ? 8'h0A : 8'h20;
    end

    assign tx.out_valid = (state_q == S_SEND);
    assign tx.out_byte  = (state_q == S_SEND) ? byte_c : 8'h00;
    assign busy         = (state_q == S_LOAD) || (state_q == S_SEND);

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ch_q         <= '0;
            fld_q        <= '0;
            // NOTE: the snapshot is reset because IDLE compares it against live inputs.
            snap_bcd_q   <= '0;
            snap_neg_q   <= '0;
            snap_unit_q  <= 1'b0;
            start_pend_q <= 1'b1;
            force_pend_q <= 1'b0;
            per_pend_q   <= 1'b0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            fld_q        <= fld_d;
            start_pend_q <= start_pend_d;
            force_pend_q <= force_pend_d;
            per_pend_q   <= per_pend_d;
            timer_q      <= timer_d;
            if (state_q == S_LOAD) begin
                snap_bcd_q  <= bcd_in;
                snap_neg_q  <= neg_in;
                snap_unit_q <= unit_f;
            end
        end
    end
endmodule

// File: tb/tb_bcd_msg_serializer.sv
// Self-checking bench: string-built reference lines compared against the captured byte stream.
`timescale 1ns/1ps
module tb_bcd_msg_serializer;
    localparam int INT_D   = 2;
    localparam int FRAC_D  = 1;
    localparam int NCH     = 2;
    localparam int PER     = 1000;
    localparam int NDIG    = INT_D + FRAC_D;
    localparam int CHW     = 4 * NDIG;
    localparam int BW      = NCH * CHW;
    localparam int MSG_LEN = NCH * (7 + INT_D + (FRAC_D > 0 ? 1 + FRAC_D : 0)) + 2 * (NCH - 1) + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [BW-1:0] bcd_in;
    logic [NCH-1:0] neg_in;
    logic          unit_f;
    logic          force_send;
    logic          busy;
    logic          msg_done;

    bcd_msg_serializer_if bus ();

    bcd_msg_serializer #(
        .INT_DIGITS(INT_D), .FRAC_DIGITS(FRAC_D), .NUM_CH(NCH), .PERIOD_CYCLES(PER)
    ) dut (
        .clk(clk), .reset(reset), .bcd_in(bcd_in), .neg_in(neg_in), .unit_f(unit_f),
        .force_send(force_send), .tx(bus), .busy(busy), .msg_done(msg_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0, done_cnt = 0, load_cnt = 0, msg_bytes = 0;
    int last_done_cyc = 0, last_load_cyc = 0, last_gap = 0;
    int mode = 0, stall_left = 0;
    bit st3 = 0, st25 = 0;
    logic [7:0] rx_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference line built directly from the text rules.
    function automatic string model(input logic [BW-1:0] bcd, input logic [NCH-1:0] neg, input logic unit);
        string s = "";
        for (int k = 0; k < NCH; k++) begin
            s = {s, $sformatf("T%0d: %s", k, neg[k] ? "-" : "+")};
            for (int d = 0; d < NDIG; d++) begin
                int n;
                if (d == INT_D) s = {s, "."};
                n = int'((bcd >> (k * CHW + 4 * (NDIG - 1 - d))) & BW'(4'hF));
                if (n > 9) s = {s, "?"};
                else       s = {s, $sformatf("%0d", n)};
            end
            s = {s, unit ? " F" : " C"};
            if (k == NCH - 1) s = {s, "\r\n"};
            else              s = {s, ", "};
        end
        return s;
    endfunction

    task automatic check_msg(input string tag, input string e);
        check({tag, "_avail"}, 32'(rx_q.size() >= e.len()), 1);
        for (int i = 0; i < e.len(); i++) begin
            logic [7:0] b;
            b = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            check($sformatf("%s_b%0d", tag, i), b, e[i]);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic pulse_force();
        force_send = 1'b1; step(); force_send = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int b = 0;
        while (done_cnt < n && b < 3000) begin @(negedge clk); b++; end
        check("wait_done", done_cnt, n);
    endtask

    task automatic wait_bytes(input int k);
        int b = 0;
        while (msg_bytes < k && b < 500) begin @(negedge clk); b++; end
        check("wait_bytes", 32'(msg_bytes >= k), 1);
    endtask

    // Monitor: transfers, stall stability, msg_done shape, LOAD timing.
    initial begin
        logic prev_v = 0, prev_r = 0, prev_done = 0, prev_busy = 0;
        logic [7:0] prev_b = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                rx_q.delete(); msg_bytes = 0;
                prev_v = 0; prev_r = 0; prev_done = 0; prev_busy = 0;
            end else begin
                if (prev_v && !prev_r) begin
                    check("stall_valid", bus.out_valid, 1);
                    check("stall_byte", bus.out_byte, prev_b);
                end
                if (bus.out_valid && bus.out_ready) begin
                    rx_q.push_back(bus.out_byte);
                    msg_bytes++;
                end
                if (msg_done) begin
                    check("done_pulse_width", prev_done, 0);
                    check("valid_after_lf", bus.out_valid, 0);
                    done_cnt++; last_done_cyc = cyc; msg_bytes = 0;
                end
                if (busy && !prev_busy) begin
                    load_cnt++; last_gap = cyc - last_done_cyc; last_load_cyc = cyc;
                end
                prev_v = bus.out_valid; prev_r = bus.out_ready; prev_b = bus.out_byte;
                prev_done = msg_done; prev_busy = busy;
            end
        end
    end

    // Ready driver: 0 = always ready, 1 = 5-cycle stalls at bytes 3 and 25 plus random, 2 = random.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            step();
            if (mode == 0) bus.out_ready = 1'b1;
            else if (stall_left > 0) begin bus.out_ready = 1'b0; stall_left--; end
            else if (mode == 1 && busy && msg_bytes == 3 && !st3) begin
                st3 = 1; bus.out_ready = 1'b0; stall_left = 4;
            end else if (mode == 1 && busy && msg_bytes == 25 && !st25) begin
                st25 = 1; bus.out_ready = 1'b0; stall_left = 4;
            end else bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_done = 0;
        int load_before, b, b_load;
        logic [BW-1:0] base_bcd;
        reset = 1'b1; bcd_in = 24'h198253; neg_in = '0; unit_f = 1'b0; force_send = 1'b0;
        repeat (3) step();
        check("rst_valid", bus.out_valid, 0);
        check("rst_byte", bus.out_byte, 0);
        check("rst_busy", busy, 0);
        check("rst_done", msg_done, 0);

        // Startup message and its latency.
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        check("lat_load_busy", busy, 1);
        check("lat_load_valid", bus.out_valid, 0);
        @(negedge clk);
        check("lat_first_valid", bus.out_valid, 1);
        check("lat_first_byte", bus.out_byte, 8'h54);
        exp_done++; wait_done(exp_done);
        check("t1_len", rx_q.size(), MSG_LEN);
        check_msg("t1", "T0: +25.3 C, T1: +19.8 C\r\n");
        repeat (200) step();
        check("t1_no_resend", done_cnt, exp_done);
        check("t1_idle", busy, 0);

        // Backpressure.
        mode = 1; st3 = 0; st25 = 0;
        pulse_force();
        exp_done++; wait_done(exp_done);
        mode = 0;
        check_msg("t2", model(bcd_in, neg_in, unit_f));
        check("t2_rest", rx_q.size(), 0);

        // Snapshot coherence.
        base_bcd = bcd_in;
        pulse_force();
        wait_bytes(10);
        bcd_in = 24'h198260;
        exp_done += 2; wait_done(exp_done);
        check_msg("t3_old", model(base_bcd, neg_in, unit_f));
        check_msg("t3_new", "T0: +26.0 C, T1: +19.8 C\r\n");
        check("t3_gap", last_gap, 2);

        // Sign, unit and invalid digit.
        bcd_in = 24'h1A5260; neg_in = 2'b10; unit_f = 1'b1;
        step();
        exp_done++; wait_done(exp_done);
        check_msg("t4", "T0: +26.0 F, T1: -1?.5 F\r\n");

        // Random readings with random backpressure.
        mode = 2;
        for (int it = 0; it < 6; it++) begin
            bcd_in = BW'($urandom); neg_in = NCH'($urandom); unit_f = 1'($urandom);
            pulse_force();
            exp_done++; wait_done(exp_done);
            repeat (5) step();
            check($sformatf("rnd%0d_quiet", it), busy, 0);
            check_msg($sformatf("rnd%0d", it), model(bcd_in, neg_in, unit_f));
            check($sformatf("rnd%0d_rest", it), rx_q.size(), 0);
        end
        mode = 0;

        // Coalesced force pulses, then the periodic resend.
        pulse_force();
        wait_bytes(1);
        for (int i = 0; i < 3; i++) begin pulse_force(); repeat (3) step(); end
        check("t5_busy_during_force", busy, 1);
        exp_done += 2; wait_done(exp_done);
        repeat (300) step();
        check("t5_one_extra", done_cnt, exp_done);
        b_load = last_load_cyc; load_before = load_cnt; b = 0;
        while (load_cnt == load_before && b < 1500) begin @(negedge clk); b++; end
        check("t5_period", last_load_cyc - b_load, PER);
        exp_done++; wait_done(exp_done);
        for (int i = 0; i < 3; i++) check_msg($sformatf("t5_m%0d", i), model(bcd_in, neg_in, unit_f));
        check("t5_rest", rx_q.size(), 0);

        // Reset in the middle of a line.
        pulse_force();
        wait_bytes(12);
        reset = 1'b1;
        #1;
        check("t6_valid_async", bus.out_valid, 0);
        check("t6_busy_async", busy, 0);
        repeat (2) step();
        reset = 1'b0;
        exp_done++; wait_done(exp_done);
        check_msg("t6", model(bcd_in, neg_in, unit_f));
        check("t6_rest", rx_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_msg_serializer.md
Name: bcd_msg_serializer

Overview:
- Parametrised successor to the single-channel temperature-to-UART text formatter.
- Turns NUM_CH channels of signed, fixed-point BCD readings into one ASCII line, for example "T0: +25.3 C, T1: +19.8 C\r\n".
- Streams the line one byte at a time over a valid/ready handshake into uart_tx.
- Adds coherent snapshots, on-change, periodic and forced triggers, sign and unit selection, and invalid-digit marking.

Parameters:
INT_DIGITS, 2, integer BCD digits per channel (1..4)
FRAC_DIGITS, 1, fractional BCD digits per channel (0..3); 0 omits the '.'
NUM_CH, 2, channel count (1..10)
PERIOD_CYCLES, 100000000, clocks between periodic resends; 0 disables periodic mode

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
bcd_in  in  NUM_CH*4*(INT_DIGITS+FRAC_DIGITS)  channel k at slice k; most significant digit in the highest nibble
neg_in  in  NUM_CH  1 = channel k is negative
unit_f  in  1  0 = 'C', 1 = 'F'
force_send  in  1  single-cycle request to send a message
out_byte  out  8  ASCII byte to uart_tx
out_valid  out  1  out_byte is valid
out_ready  in  1  uart_tx accepts the byte
busy  out  1  high in LOAD and SEND
msg_done  out  1  1-cycle pulse after the final LF is accepted

Behaviour:
- Reset values: out_valid=0, out_byte=0, busy=0, msg_done=0, state IDLE, timer 0.
  - snap_last cleared to zero; force_pend cleared.
  - start_pend set to 1, so one message is always sent after reset.
- Message format, per channel k in 0..NUM_CH-1:
  - Bytes in order: 'T', 0x30+k, ':', ' ', sign, INT_DIGITS digits, then '.' plus FRAC_DIGITS digits (only if FRAC_DIGITS>0), ' ', unit.
  - Sign is '-' (0x2D) if neg_in[k] is set, otherwise '+' (0x2B). Unit is 'C' (0x43) or 'F' (0x46).
  - Between channels: ',' ' '. After the last channel: 0x0D 0x0A.
  - Digit byte = 0x30+nibble; a nibble >9 emits '?' (0x3F). Leading zeros are kept (fixed width).
- Message length: NUM_CH*(7+INT_DIGITS+(FRAC_DIGITS>0 ? 1+FRAC_DIGITS : 0)) + 2*(NUM_CH-1) + 2. Defaults give 26 bytes.
- Trigger, evaluated in IDLE only:
  - start_pend, or force_pend, or per_pend,
  - or {bcd_in, neg_in, unit_f} != snap_last.
- FSM states and transitions:
  - IDLE: go to LOAD on a trigger.
  - LOAD: one cycle. Capture {bcd_in, neg_in, unit_f} into snap and snap_last. Clear start_pend, force_pend, per_pend and the timer.
  - SEND: drive bytes from snap, using a channel index and a field index.
  - DONE: one cycle. Pulse msg_done, then return to IDLE.
- Latency: the first out_valid is asserted in the cycle after LOAD, i.e. 2 clocks after the triggering edge.
- Handshake:
  - A byte transfers on a clock edge where out_valid && out_ready.
  - While out_valid && !out_ready, out_byte and out_valid hold stable.
  - After a transfer the next byte is valid on the next cycle, so back-to-back transfers are allowed at full rate.
  - out_valid drops after LF is accepted.
- Input changes during LOAD or SEND never affect the message in flight (snapshot coherence). The difference is detected in IDLE and triggers a new message.
- force_send:
  - A pulse in any state sets force_pend.
  - Multiple pulses before the next LOAD coalesce into one message.
  - A pulse in the same cycle as LOAD is retained for the next message.
- Timer:
  - Counts every clock and saturates; cleared in LOAD.
  - When PERIOD_CYCLES>0 and the timer reaches PERIOD_CYCLES-1, set per_pend.
  - If the message is longer than the period, the resend starts immediately after DONE.
- Reset mid-message: out_valid falls asynchronously. After release the bench sees a complete new message starting with 'T'; partial lines are not resumed.
- Counters are sized with $clog2 of the field and channel counts; there is no wrap-around within a message.

Test Plan:
- Defaults, out_ready=1, ch0 bcd=0x253, ch1 bcd=0x198, neg=0, unit_f=0, reset released -> exactly "T0: +25.3 C, T1: +19.8 C\r\n" (26 bytes), one msg_done, then idle with no resend while inputs are stable.
- Same message with out_ready low for 5 cycles at bytes 3 and 25, plus a random toggle -> out_byte stable while stalled, and the 26 bytes arrive in order with no drops or duplicates.
- ch0 changed from 0x253 to 0x260 at byte 10 -> the current message still reads "+25.3"; the next message starts immediately after msg_done and reads "+26.0".
- neg_in=2'b10, unit_f=1, ch1=0x1A5 -> ch1 field reads "-1?.5 F" and ch0 reads "... F".
- PERIOD_CYCLES=1000, inputs stable; force_send pulsed 3 times while busy -> one extra message after the current one; periodic messages start 1000 clocks after each LOAD.
- Reset asserted during byte 12 -> out_valid=0 and busy=0 within the same cycle; after release the full 26-byte message is resent from 'T'.
